// File: rtl/ahb_bridge_pkg.sv
// Shared types and encodings for the registered AHB slave-to-master bridge.
//   state_e       : bridge FSM states
//   ahb_ctrl_t    : captured per-beat control payload (write/size/prot)
//   HTRANS_*      : AHB transfer types
//   HRESP_*       : AHB response codes
//   HBURST_SINGLE : burst encoding used on every issued beat
//   REMAP_*       : upper-address remap mode encodings
package ahb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR1 = 3'd4,
        ST_ERR2 = 3'd5
    } state_e;

    typedef struct packed {
        logic       write;
        logic [2:0] size;
        logic [3:0] prot;
    } ahb_ctrl_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam int unsigned REMAP_PASS  = 0;
    localparam int unsigned REMAP_CONST = 1;
    localparam int unsigned REMAP_PORT  = 2;

endpackage

// File: rtl/ahb_bridge_timeout.sv
// Master-side stall watchdog with sticky flag.
//   clk, rst_n   : clock, async active-low reset
//   start_i      : a new beat is being launched (clears the counter)
//   active_i     : bridge is waiting on the master (ADDR or DATA)
//   stall_i      : master HREADY low this cycle
//   clr_i        : clears the sticky flag (a same-cycle expiry wins)
//   expire_c_o   : combinational; this stall cycle reaches the limit
//   flag_o       : sticky timeout flag
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module ahb_bridge_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic active_i,
    input  logic stall_i,
    input  logic clr_i,
    output logic expire_c_o,
    output logic flag_o
);

    localparam int unsigned LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam int unsigned CNT_W = (LAST < 2) ? 1 : $clog2(LAST + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;

    // Expiry fires on the TIMEOUT_CYCLES-th stall cycle counted since launch.
    always_comb begin
        expire_c_o = 1'b0;
        cnt_d      = cnt_q;
        flag_d     = flag_q;
        if (TIMEOUT_CYCLES != 0) begin
            expire_c_o = active_i & stall_i & (cnt_q == CNT_W'(LAST));
        end
        if (start_i) begin
            cnt_d = '0;
        end else if (active_i && stall_i && !expire_c_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (clr_i) begin
            flag_d = 1'b0;
        end
        if (expire_c_o) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/ahb_slv2mst_bridge_pipe.sv
// Registered AHB-Lite slave-to-master bridge. Each accepted slave beat is
// re-issued on the master port as NONSEQ/SINGLE with optional upper-address
// remap; no combinational path from slave inputs to master outputs.
//   clock, resetn        : clock, async active-low reset
//   *_SLAVE              : AHB-Lite slave port (HREADYOUT/HRDATA/HRESP out)
//   *_MASTER             : AHB-Lite master port (HREADY/HRDATA/HRESP in)
//   remap_addr           : upper address bits used in remap mode 2
//   timeout_clr          : clears timeout_flag
//   timeout_flag         : sticky, set when a master beat is aborted on stall
module ahb_slv2mst_bridge_pipe #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned REMAP_BITS     = 4,
    parameter int unsigned REMAP_MODE     = 1,
    parameter int unsigned REMAP_VALUE    = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  HSEL_SLAVE,
    input  logic [ADDR_W-1:0]     HADDR_SLAVE,
    input  logic [1:0]            HTRANS_SLAVE,
    input  logic                  HWRITE_SLAVE,
    input  logic [2:0]            HSIZE_SLAVE,
    input  logic [2:0]            HBURST_SLAVE,
    input  logic [3:0]            HPROT_SLAVE,
    input  logic                  HMASTLOCK_SLAVE,
    input  logic [DATA_W-1:0]     HWDATA_SLAVE,
    input  logic                  HREADY_SLAVE,
    output logic                  HREADYOUT_SLAVE,
    output logic [DATA_W-1:0]     HRDATA_SLAVE,
    output logic [1:0]            HRESP_SLAVE,
    output logic [ADDR_W-1:0]     HADDR_MASTER,
    output logic [1:0]            HTRANS_MASTER,
    output logic                  HWRITE_MASTER,
    output logic [2:0]            HSIZE_MASTER,
    output logic [2:0]            HBURST_MASTER,
    output logic [3:0]            HPROT_MASTER,
    output logic                  HMASTLOCK_MASTER,
    output logic [DATA_W-1:0]     HWDATA_MASTER,
    input  logic                  HREADY_MASTER,
    input  logic [DATA_W-1:0]     HRDATA_MASTER,
    input  logic [1:0]            HRESP_MASTER,
    input  logic [REMAP_BITS-1:0] remap_addr,
    input  logic                  timeout_clr,
    output logic                  timeout_flag
);

    import ahb_bridge_pkg::*;

    state_e            state_q, state_d;
    ahb_ctrl_t         ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d, addr_remap_c;
    logic [DATA_W-1:0] hwdata_q, hwdata_d, hrdata_q, hrdata_d;
    logic [1:0]        htrans_q, htrans_d, hresp_q, hresp_d;
    logic              hreadyout_q, hreadyout_d;
    logic              lock_q, lock_d;
    logic              wpend_q;
    logic              accept_c, load_c, expire_c, active_c;
    logic              unused_c;

    // Burst type and SEQ/NONSEQ distinction are deliberately dropped.
    assign unused_c = ^{HBURST_SLAVE, HTRANS_SLAVE[0], remap_addr};

    assign accept_c = HSEL_SLAVE & HTRANS_SLAVE[1] & HREADY_SLAVE;
    assign load_c   = accept_c & ((state_q == ST_IDLE) | (state_q == ST_RESP) |
                                  (state_q == ST_ERR2));
    assign active_c = (state_q == ST_ADDR) | (state_q == ST_DATA);

    // Upper-address remap on the issued address only.
    always_comb begin
        addr_remap_c = HADDR_SLAVE;
        if (REMAP_MODE == REMAP_CONST) begin
            addr_remap_c[ADDR_W-1 -: REMAP_BITS] = REMAP_BITS'(REMAP_VALUE);
        end else if (REMAP_MODE == REMAP_PORT) begin
            addr_remap_c[ADDR_W-1 -: REMAP_BITS] = remap_addr;
        end
    end

    ahb_bridge_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clock),
        .rst_n      (resetn),
        .start_i    (load_c),
        .active_i   (active_c),
        .stall_i    (~HREADY_MASTER),
        .clr_i      (timeout_clr),
        .expire_c_o (expire_c),
        .flag_o     (timeout_flag)
    );

    // Next state and next registered outputs; outputs follow state_d.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_ADDR;
            ST_ADDR: begin
                if (expire_c)           state_d = ST_ERR1;
                else if (HREADY_MASTER) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (expire_c) begin
                    state_d = ST_ERR1;
                end else if (HREADY_MASTER) begin
                    state_d = (HRESP_MASTER == HRESP_ERROR) ? ST_ERR1 : ST_RESP;
                end
            end
            ST_RESP, ST_ERR2: state_d = accept_c ? ST_ADDR : ST_IDLE;
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        hreadyout_d = (state_d == ST_IDLE) | (state_d == ST_RESP) | (state_d == ST_ERR2);
        hresp_d     = ((state_d == ST_ERR1) | (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        htrans_d    = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;

        haddr_d = load_c ? addr_remap_c : haddr_q;
        ctrl_d  = ctrl_q;
        if (load_c) begin
            ctrl_d.write = HWRITE_SLAVE;
            ctrl_d.size  = HSIZE_SLAVE;
            ctrl_d.prot  = HPROT_SLAVE;
        end

        // Lock is held across the whole ADDR+DATA span of the beat.
        lock_d = 1'b0;
        if ((state_d == ST_ADDR) || (state_d == ST_DATA)) begin
            lock_d = load_c ? HMASTLOCK_SLAVE : lock_q;
        end

        // Slave write data is valid in the cycle after the accept.
        hwdata_d = wpend_q ? HWDATA_SLAVE : hwdata_q;

        hrdata_d = hrdata_q;
        if ((state_q == ST_DATA) && HREADY_MASTER && (HRESP_MASTER != HRESP_ERROR)) begin
            hrdata_d = HRDATA_MASTER;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            ctrl_q      <= '0;
            lock_q      <= 1'b0;
            hwdata_q    <= '0;
            hrdata_q    <= '0;
            wpend_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            ctrl_q      <= ctrl_d;
            lock_q      <= lock_d;
            hwdata_q    <= hwdata_d;
            hrdata_q    <= hrdata_d;
            wpend_q     <= load_c;
        end
    end

    assign HREADYOUT_SLAVE  = hreadyout_q;
    assign HRESP_SLAVE      = hresp_q;
    assign HRDATA_SLAVE     = hrdata_q;
    assign HADDR_MASTER     = haddr_q;
    assign HTRANS_MASTER    = htrans_q;
    assign HWRITE_MASTER    = ctrl_q.write;
    assign HSIZE_MASTER     = ctrl_q.size;
    assign HPROT_MASTER     = ctrl_q.prot;
    assign HBURST_MASTER    = HBURST_SINGLE;
    assign HMASTLOCK_MASTER = lock_q;
    assign HWDATA_MASTER    = hwdata_q;

endmodule

// File: tb/tb_ahb_slv2mst_bridge_pipe.sv
// Directed bench for ahb_slv2mst_bridge_pipe. Instance u_dut uses remap mode 2
// (remap_addr port); u_dut_c uses mode 1 with constant 0x6. Both share inputs.
module tb_ahb_slv2mst_bridge_pipe;

    import ahb_bridge_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned RB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          hsel, hwrite, hlock, hready_m, to_clr;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans, hresp_m;
    logic [2:0]    hsize, hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata, hrdata_m;
    logic [RB-1:0] remap;

    logic          a_hreadyout, a_hwrite, a_lock, a_flag;
    logic [DW-1:0] a_hrdata, a_hwdata;
    logic [1:0]    a_hresp, a_htrans;
    logic [AW-1:0] a_haddr;
    logic [2:0]    a_hsize, a_hburst;
    logic [3:0]    a_hprot;

    logic          b_hreadyout, b_hwrite, b_lock, b_flag;
    logic [DW-1:0] b_hrdata, b_hwdata;
    logic [1:0]    b_hresp, b_htrans;
    logic [AW-1:0] b_haddr;
    logic [2:0]    b_hsize, b_hburst;
    logic [3:0]    b_hprot;
    logic          b_unused;

    assign b_unused = ^{b_hreadyout, b_hwrite, b_lock, b_flag, b_hrdata, b_hwdata,
                        b_hresp, b_htrans, b_hsize, b_hburst, b_hprot};

    ahb_slv2mst_bridge_pipe #(
        .ADDR_W(AW), .DATA_W(DW), .REMAP_BITS(RB), .REMAP_MODE(2),
        .REMAP_VALUE(0), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clock(clk), .resetn(rst_n),
        .HSEL_SLAVE(hsel), .HADDR_SLAVE(haddr), .HTRANS_SLAVE(htrans),
        .HWRITE_SLAVE(hwrite), .HSIZE_SLAVE(hsize), .HBURST_SLAVE(hburst),
        .HPROT_SLAVE(hprot), .HMASTLOCK_SLAVE(hlock), .HWDATA_SLAVE(hwdata),
        .HREADY_SLAVE(a_hreadyout), .HREADYOUT_SLAVE(a_hreadyout),
        .HRDATA_SLAVE(a_hrdata), .HRESP_SLAVE(a_hresp),
        .HADDR_MASTER(a_haddr), .HTRANS_MASTER(a_htrans), .HWRITE_MASTER(a_hwrite),
        .HSIZE_MASTER(a_hsize), .HBURST_MASTER(a_hburst), .HPROT_MASTER(a_hprot),
        .HMASTLOCK_MASTER(a_lock), .HWDATA_MASTER(a_hwdata),
        .HREADY_MASTER(hready_m), .HRDATA_MASTER(hrdata_m), .HRESP_MASTER(hresp_m),
        .remap_addr(remap), .timeout_clr(to_clr), .timeout_flag(a_flag)
    );

    ahb_slv2mst_bridge_pipe #(
        .ADDR_W(AW), .DATA_W(DW), .REMAP_BITS(RB), .REMAP_MODE(1),
        .REMAP_VALUE(6), .TIMEOUT_CYCLES(16)
    ) u_dut_c (
        .clock(clk), .resetn(rst_n),
        .HSEL_SLAVE(hsel), .HADDR_SLAVE(haddr), .HTRANS_SLAVE(htrans),
        .HWRITE_SLAVE(hwrite), .HSIZE_SLAVE(hsize), .HBURST_SLAVE(hburst),
        .HPROT_SLAVE(hprot), .HMASTLOCK_SLAVE(hlock), .HWDATA_SLAVE(hwdata),
        .HREADY_SLAVE(a_hreadyout), .HREADYOUT_SLAVE(b_hreadyout),
        .HRDATA_SLAVE(b_hrdata), .HRESP_SLAVE(b_hresp),
        .HADDR_MASTER(b_haddr), .HTRANS_MASTER(b_htrans), .HWRITE_MASTER(b_hwrite),
        .HSIZE_MASTER(b_hsize), .HBURST_MASTER(b_hburst), .HPROT_MASTER(b_hprot),
        .HMASTLOCK_MASTER(b_lock), .HWDATA_MASTER(b_hwdata),
        .HREADY_MASTER(hready_m), .HRDATA_MASTER(hrdata_m), .HRESP_MASTER(hresp_m),
        .remap_addr(remap), .timeout_clr(to_clr), .timeout_flag(b_flag)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hlock  = 1'b0;
        hburst = 3'b000;
    endtask

    task automatic drive_addr(input logic [AW-1:0] a, input logic w,
                              input logic [1:0] t, input logic [2:0] b);
        hsel   = 1'b1;
        haddr  = a;
        hwrite = w;
        htrans = t;
        hburst = b;
        hsize  = 3'd2;
        hprot  = 4'h3;
        hlock  = 1'b0;
    endtask

    initial begin
        int nonseq_cnt;
        idle_bus();
        haddr = '0; hsize = '0; hprot = '0; hwdata = '0;
        hready_m = 1'b1; hrdata_m = '0; hresp_m = HRESP_OKAY;
        remap = 4'h6; to_clr = 1'b0;
        rst_n = 1'b0;
        #12;
        check("rst_hreadyout", a_hreadyout, 1);
        check("rst_hresp", a_hresp, 0);
        check("rst_htrans", a_htrans, 0);
        check("rst_haddr", a_haddr, 0);
        check("rst_hrdata", a_hrdata, 0);
        check("rst_flag", a_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single locked write, zero-wait master
        drive_addr(32'h0000_1000, 1'b1, HTRANS_NONSEQ, 3'b000);
        hlock = 1'b1;
        check("wr_t0_hreadyout", a_hreadyout, 1);
        tick();
        idle_bus();
        hwdata = 32'hDEAD_BEEF;
        check("wr_t1_htrans", a_htrans, HTRANS_NONSEQ);
        check("wr_t1_haddr_mode1", b_haddr, 32'h6000_1000);
        check("wr_t1_haddr_mode2", a_haddr, 32'h6000_1000);
        check("wr_t1_hwrite", a_hwrite, 1);
        check("wr_t1_hsize", a_hsize, 2);
        check("wr_t1_hprot", a_hprot, 4'h3);
        check("wr_t1_hreadyout", a_hreadyout, 0);
        tick();
        check("wr_t2_htrans", a_htrans, HTRANS_IDLE);
        check("wr_t2_hwdata", a_hwdata, 32'hDEAD_BEEF);
        check("wr_t2_lock", a_lock, 1);
        check("wr_t2_hreadyout", a_hreadyout, 0);
        tick();
        check("wr_t3_hreadyout", a_hreadyout, 1);
        check("wr_t3_hresp", a_hresp, HRESP_OKAY);

        // Read with 3 master wait states, accepted in RESP
        remap = 4'hA;
        drive_addr(32'h2000_0040, 1'b0, HTRANS_NONSEQ, 3'b000);
        tick();
        idle_bus();
        check("rd_haddr_mode2", a_haddr, 32'hA000_0040);
        check("rd_haddr_mode1", b_haddr, 32'h6000_0040);
        check("rd_hwrite", a_hwrite, 0);
        tick();
        hready_m = 1'b0;
        repeat (2) tick();
        check("rd_wait_hreadyout", a_hreadyout, 0);
        check("rd_wait_htrans", a_htrans, HTRANS_IDLE);
        tick();
        hready_m = 1'b1;
        hrdata_m = 32'h1234_5678;
        tick();
        hrdata_m = '0;
        check("rd_hrdata", a_hrdata, 32'h1234_5678);
        check("rd_hreadyout", a_hreadyout, 1);
        check("rd_hresp", a_hresp, HRESP_OKAY);

        // Master ERROR on a write; next beat accepted in ERR2
        drive_addr(32'h0000_0200, 1'b1, HTRANS_NONSEQ, 3'b000);
        tick();
        idle_bus();
        hwdata = 32'h55AA_55AA;
        tick();
        hresp_m = HRESP_ERROR;
        tick();
        hresp_m = HRESP_OKAY;
        check("err1_hreadyout", a_hreadyout, 0);
        check("err1_hresp", a_hresp, HRESP_ERROR);
        tick();
        check("err2_hreadyout", a_hreadyout, 1);
        check("err2_hresp", a_hresp, HRESP_ERROR);
        drive_addr(32'h0000_0300, 1'b0, HTRANS_NONSEQ, 3'b000);
        tick();
        idle_bus();
        check("err_next_htrans", a_htrans, HTRANS_NONSEQ);
        check("err_next_haddr", a_haddr, 32'hA000_0300);
        check("err_next_hresp", a_hresp, HRESP_OKAY);
        tick();
        hrdata_m = 32'h0BAD_F00D;
        tick();
        hrdata_m = '0;
        check("err_next_hrdata", a_hrdata, 32'h0BAD_F00D);
        check("err_next_hreadyout", a_hreadyout, 1);

        // Timeout after 16 stall cycles; late response ignored
        drive_addr(32'h0000_0400, 1'b1, HTRANS_NONSEQ, 3'b000);
        tick();
        idle_bus();
        hready_m = 1'b0;
        repeat (15) tick();
        check("to_stall16_htrans", a_htrans, HTRANS_NONSEQ);
        check("to_stall16_flag", a_flag, 0);
        tick();
        check("to_err1_htrans", a_htrans, HTRANS_IDLE);
        check("to_err1_hresp", a_hresp, HRESP_ERROR);
        check("to_err1_hreadyout", a_hreadyout, 0);
        check("to_err1_flag", a_flag, 1);
        tick();
        hready_m = 1'b1;
        hresp_m  = HRESP_ERROR;
        hrdata_m = 32'hFFFF_FFFF;
        check("to_err2_hreadyout", a_hreadyout, 1);
        tick();
        hresp_m  = HRESP_OKAY;
        hrdata_m = '0;
        check("to_late_hresp", a_hresp, HRESP_OKAY);
        check("to_late_hreadyout", a_hreadyout, 1);
        check("to_late_hrdata", a_hrdata, 32'h0BAD_F00D);
        check("to_flag_sticky", a_flag, 1);
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        check("to_flag_cleared", a_flag, 0);

        // Expiry while timeout_clr is held: set wins
        drive_addr(32'h0000_0480, 1'b1, HTRANS_NONSEQ, 3'b000);
        tick();
        idle_bus();
        hready_m = 1'b0;
        to_clr   = 1'b1;
        repeat (16) tick();
        check("to_set_wins_flag", a_flag, 1);
        to_clr   = 1'b0;
        hready_m = 1'b1;
        repeat (2) tick();

        // Back-to-back INCR4 write burst from 0x100
        hrdata_m   = 32'h7777_7777;
        nonseq_cnt = 0;
        for (int c = 0; c <= 12; c++) begin
            if (c == 0)      drive_addr(32'h0000_0100, 1'b1, HTRANS_NONSEQ, 3'b011);
            else if (c <= 9) drive_addr(32'h0000_0100 + 32'(4 * ((c + 2) / 3)), 1'b1, HTRANS_SEQ, 3'b011);
            else             idle_bus();
            if (c >= 1) hwdata = 32'hB000_0000 + 32'((c - 1) / 3);
            if (c % 3 == 1) begin
                check("burst_htrans", a_htrans, HTRANS_NONSEQ);
                check("burst_haddr", a_haddr, 32'hA000_0100 + 32'(4 * ((c - 1) / 3)));
                check("burst_hburst", a_hburst, HBURST_SINGLE);
            end
            if (c % 3 == 2) check("burst_hwdata", a_hwdata, 32'hB000_0000 + 32'((c - 1) / 3));
            if (c % 3 == 0 && c > 0) check("burst_hreadyout", a_hreadyout, 1);
            if (a_htrans == HTRANS_NONSEQ) nonseq_cnt++;
            tick();
        end
        check("burst_beat_count", 64'(nonseq_cnt), 4);

        // Reset dropped during DATA, then a clean read
        drive_addr(32'h0000_0500, 1'b0, HTRANS_NONSEQ, 3'b000);
        tick();
        idle_bus();
        tick();
        hready_m = 1'b0;
        check("rst_mid_pre_hreadyout", a_hreadyout, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_hreadyout", a_hreadyout, 1);
        check("rst_mid_htrans", a_htrans, HTRANS_IDLE);
        check("rst_mid_haddr", a_haddr, 0);
        check("rst_mid_hwdata", a_hwdata, 0);
        check("rst_mid_hrdata", a_hrdata, 0);
        check("rst_mid_flag", a_flag, 0);
        check("rst_mid_hresp", a_hresp, HRESP_OKAY);
        #2;
        rst_n    = 1'b1;
        hready_m = 1'b1;
        hrdata_m = '0;
        tick();
        check("post_rst_htrans", a_htrans, HTRANS_IDLE);
        check("post_rst_hreadyout", a_hreadyout, 1);
        drive_addr(32'h0000_0600, 1'b0, HTRANS_NONSEQ, 3'b000);
        tick();
        idle_bus();
        check("post_rst_haddr", a_haddr, 32'hA000_0600);
        tick();
        hrdata_m = 32'hCAFE_F00D;
        tick();
        hrdata_m = '0;
        check("post_rst_hrdata", a_hrdata, 32'hCAFE_F00D);
        check("post_rst_hresp", a_hresp, HRESP_OKAY);
        check("post_rst_rdy", a_hreadyout, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
